// File: rtl/peripheral_apb4_cmd_master_if.sv
// Bundle of command/response streams and APB4 bus signals for the command master.
// The master modport is the DUT view; the slave modport is the command source plus APB target.
interface peripheral_apb4_cmd_master_if #(
    parameter int PADDR_SIZE = 16,
    parameter int PDATA_SIZE = 32
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [PADDR_SIZE-1:0]     cmd_addr;
    logic [PDATA_SIZE/8-1:0]   cmd_strb;
    logic [PDATA_SIZE-1:0]     cmd_wdata;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [PDATA_SIZE-1:0]     rsp_rdata;
    logic                      rsp_err;
    logic                      rsp_timeout;

    logic                      busy;

    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [PADDR_SIZE-1:0]     PADDR;
    logic [PDATA_SIZE/8-1:0]   PSTRB;
    logic [PDATA_SIZE-1:0]     PWDATA;
    logic [PDATA_SIZE-1:0]     PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_strb, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output busy,
        output PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_strb, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  busy,
        input  PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/peripheral_apb4_cmd_master.sv
// APB4 master: buffered command stream in, one APB transfer at a time, buffered responses out.
// Transfers abort with a timeout response when PREADY stays low too long.
module peripheral_apb4_cmd_master_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    cnt_q,
    output logic [CW-1:0]    cnt_d
);
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: the count gates every consumer of head.
    always_ff @(posedge PCLK) begin
        if (push) mem_q[wptr_q] <= din;
    end

    assign head = mem_q[rptr_q];
endmodule

module peripheral_apb4_cmd_master #(
    parameter int PADDR_SIZE = 16,
    parameter int PDATA_SIZE = 32,
    parameter int CMD_DEPTH  = 4,
    parameter int RSP_DEPTH  = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    peripheral_apb4_cmd_master_if.master bus
);
    localparam int SW  = PDATA_SIZE / 8;
    localparam int CCW = $clog2(CMD_DEPTH + 1);
    localparam int RCW = $clog2(RSP_DEPTH + 1);
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    typedef struct packed {
        logic                  write;
        logic [PADDR_SIZE-1:0] addr;
        logic [SW-1:0]         strb;
        logic [PDATA_SIZE-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [PDATA_SIZE-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } rsp_t;

    state_t        state_q, state_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          busy_q, busy_d;

    cmd_t           cmd_in, cmd_head;
    rsp_t           rsp_in, rsp_head;
    logic [CCW-1:0] cmd_cnt_q, cmd_cnt_d;
    logic [RCW-1:0] rsp_cnt_q, rsp_cnt_d;
    logic           cmd_push, cmd_pop, rsp_push, rsp_pop;
    logic           rsp_valid;
    logic           done, abort, finish, launch;

    assign cmd_in = '{write: bus.cmd_write, addr: bus.cmd_addr,
                      strb: bus.cmd_strb, wdata: bus.cmd_wdata};

    assign cmd_push  = bus.cmd_valid && cmd_ready_q;
    assign rsp_valid = (rsp_cnt_q != '0);
    assign rsp_pop   = rsp_valid && bus.rsp_ready;

    assign done   = (state_q == ACCESS) && bus.PREADY;
    assign abort  = (TIMEOUT != 0) && (state_q == ACCESS) && !bus.PREADY
                    && (wait_cnt_q == WAIT_LAST);
    assign finish = done || abort;

    assign cmd_pop  = finish;
    assign rsp_push = finish;

    // Launch looks at post-update counts so a finishing transfer can chain straight into SETUP.
    assign launch = (cmd_cnt_d != '0) && (rsp_cnt_d < RCW'(RSP_DEPTH));

    always_comb begin
        rsp_in.rdata   = (abort || cmd_head.write) ? '0 : bus.PRDATA;
        rsp_in.err     = abort || bus.PSLVERR;
        rsp_in.timeout = abort;
    end

    peripheral_apb4_cmd_master_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .push    (cmd_push),
        .din     (cmd_in),
        .pop     (cmd_pop),
        .head    (cmd_head),
        .cnt_q   (cmd_cnt_q),
        .cnt_d   (cmd_cnt_d)
    );

    peripheral_apb4_cmd_master_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .push    (rsp_push),
        .din     (rsp_in),
        .pop     (rsp_pop),
        .head    (rsp_head),
        .cnt_q   (rsp_cnt_q),
        .cnt_d   (rsp_cnt_d)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (launch) state_d = SETUP;
            end
            SETUP: begin
                state_d    = ACCESS;
                wait_cnt_d = '0;
            end
            ACCESS: begin
                if (finish) begin
                    state_d = launch ? SETUP : IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (cmd_cnt_d != CCW'(CMD_DEPTH));
        busy_d      = (cmd_cnt_d != '0) || (state_d != IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    // APB fields come straight from the FIFO head, which is stable until the completion pop.
    always_comb begin
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = '0;
        bus.PSTRB   = '0;
        bus.PWDATA  = '0;
        if (state_q != IDLE) begin
            bus.PSEL    = 1'b1;
            bus.PENABLE = (state_q == ACCESS);
            bus.PWRITE  = cmd_head.write;
            bus.PADDR   = cmd_head.addr;
            bus.PSTRB   = cmd_head.write ? cmd_head.strb  : '0;
            bus.PWDATA  = cmd_head.write ? cmd_head.wdata : '0;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.busy        = busy_q;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_rdata   = rsp_valid ? rsp_head.rdata : '0;
    assign bus.rsp_err     = rsp_valid && rsp_head.err;
    assign bus.rsp_timeout = rsp_valid && rsp_head.timeout;
endmodule

// File: tb/tb_peripheral_apb4_cmd_master.sv
// Directed bench for the APB4 command master: write, waited read, back-pressure,
// slave error, timeout and reset during a wait state.
module tb_peripheral_apb4_cmd_master;
    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_acc;

    always #5 PCLK = ~PCLK;

    peripheral_apb4_cmd_master_if #(.PADDR_SIZE(16), .PDATA_SIZE(32)) bus ();

    peripheral_apb4_cmd_master #(
        .PADDR_SIZE(16), .PDATA_SIZE(32), .CMD_DEPTH(4), .RSP_DEPTH(2), .TIMEOUT(16)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge PCLK);
    endtask

    task automatic set_cmd(input logic wr, input logic [15:0] a, input logic [3:0] s,
                           input logic [31:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_strb  = s;
        bus.cmd_wdata = d;
    endtask

    task automatic pop_rsp();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("rsp_drained", bus.rsp_valid, 0);
    endtask

    initial begin
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0;
        bus.cmd_strb = 0;  bus.cmd_wdata = 0; bus.rsp_ready = 0;
        bus.PRDATA = 0;    bus.PREADY = 1;    bus.PSLVERR = 0;

        // Reset state
        tick(); tick();
        chk("rst_psel",      bus.PSEL, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy",      bus.busy, 0);
        PRESETn = 1'b1;
        tick();
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);

        // Single zero-wait write
        set_cmd(1'b1, 16'h0010, 4'hF, 32'hDEADBEEF);
        tick();
        bus.cmd_valid = 0;
        chk("wr_setup_psel",   bus.PSEL, 1);
        chk("wr_setup_pen",    bus.PENABLE, 0);
        chk("wr_setup_paddr",  bus.PADDR, 32'h0010);
        chk("wr_setup_pwrite", bus.PWRITE, 1);
        chk("wr_setup_pstrb",  bus.PSTRB, 4'hF);
        chk("wr_setup_pwdata", bus.PWDATA, 32'hDEADBEEF);
        chk("wr_setup_busy",   bus.busy, 1);
        chk("wr_setup_rspv",   bus.rsp_valid, 0);
        tick();
        chk("wr_acc_psel", bus.PSEL, 1);
        chk("wr_acc_pen",  bus.PENABLE, 1);
        tick();
        chk("wr_done_psel",  bus.PSEL, 0);
        chk("wr_rsp_valid",  bus.rsp_valid, 1);
        chk("wr_rsp_err",    bus.rsp_err, 0);
        chk("wr_rsp_rdata",  bus.rsp_rdata, 0);
        chk("wr_done_busy",  bus.busy, 0);
        pop_rsp();

        // Read with 3 wait states
        bus.PREADY = 0;
        set_cmd(1'b0, 16'h0020, 4'hF, 32'hFFFFFFFF);
        tick();
        bus.cmd_valid = 0;
        chk("rd_setup_pwrite", bus.PWRITE, 0);
        chk("rd_setup_paddr",  bus.PADDR, 32'h0020);
        chk("rd_setup_pstrb",  bus.PSTRB, 0);
        chk("rd_setup_pwdata", bus.PWDATA, 0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            chk("rd_acc_psel",  bus.PSEL, 1);
            chk("rd_acc_pen",   bus.PENABLE, 1);
            chk("rd_acc_pstrb", bus.PSTRB, 0);
            if (i == 4) begin
                bus.PREADY = 1;
                bus.PRDATA = 32'h12345678;
            end
            tick();
        end
        bus.PRDATA = 0;
        chk("rd_done_psel",  bus.PSEL, 0);
        chk("rd_rsp_valid",  bus.rsp_valid, 1);
        chk("rd_rsp_rdata",  bus.rsp_rdata, 32'h12345678);
        chk("rd_rsp_err",    bus.rsp_err, 0);
        chk("rd_rsp_tmo",    bus.rsp_timeout, 0);
        pop_rsp();

        // Four back-to-back writes with responses held off
        for (int i = 0; i < 4; i++) begin
            set_cmd(1'b1, 16'h0100 + 16'(i), 4'hF, 32'(i));
            tick();
            chk("q_psel",      bus.PSEL, 1);
            chk("q_pen",       bus.PENABLE, 32'(i % 2));
            chk("q_paddr",     bus.PADDR, 32'h0100 + 32'(i / 2));
            chk("q_cmd_ready", bus.cmd_ready, 1);
        end
        bus.cmd_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_psel",      bus.PSEL, 0);
            chk("bp_cmd_ready", bus.cmd_ready, 1);
            chk("bp_busy",      bus.busy, 1);
            chk("bp_rsp_valid", bus.rsp_valid, 1);
        end
        bus.rsp_ready = 1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("rel_psel",  bus.PSEL, 1);
            chk("rel_pen",   bus.PENABLE, 32'(j % 2));
            chk("rel_paddr", bus.PADDR, 32'h0102 + 32'(j / 2));
        end
        tick();
        chk("rel_done_psel", bus.PSEL, 0);
        chk("rel_done_busy", bus.busy, 0);
        chk("rel_rsp_valid", bus.rsp_valid, 1);
        tick();
        chk("rel_rsp_empty", bus.rsp_valid, 0);
        bus.rsp_ready = 0;

        // Read completing with PSLVERR
        set_cmd(1'b0, 16'h0030, 4'h0, 32'h0);
        tick();
        bus.cmd_valid = 0;
        bus.PSLVERR = 1;
        bus.PRDATA  = 32'hAAAA5555;
        tick(); tick();
        bus.PSLVERR = 0;
        bus.PRDATA  = 0;
        chk("err_rsp_valid", bus.rsp_valid, 1);
        chk("err_rsp_err",   bus.rsp_err, 1);
        chk("err_rsp_tmo",   bus.rsp_timeout, 0);
        chk("err_rsp_rdata", bus.rsp_rdata, 32'hAAAA5555);
        pop_rsp();

        // Write that never gets PREADY: aborts after 16 ACCESS cycles
        bus.PREADY = 0;
        set_cmd(1'b1, 16'h0040, 4'h3, 32'h0BADF00D);
        tick();
        bus.cmd_valid = 0;
        n_acc = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.PSEL && bus.PENABLE) n_acc++;
            else break;
        end
        chk("tmo_access_cycles", n_acc, 16);
        chk("tmo_psel",      bus.PSEL, 0);
        chk("tmo_rsp_valid", bus.rsp_valid, 1);
        chk("tmo_rsp_err",   bus.rsp_err, 1);
        chk("tmo_rsp_tmo",   bus.rsp_timeout, 1);
        chk("tmo_rsp_rdata", bus.rsp_rdata, 0);
        chk("tmo_busy",      bus.busy, 0);
        pop_rsp();

        // Reset during a wait state with two commands queued behind the active one
        for (int i = 0; i < 3; i++) begin
            set_cmd(1'b1, 16'h0200 + 16'(i), 4'hF, 32'h11110000 + 32'(i));
            tick();
        end
        bus.cmd_valid = 0;
        tick();
        chk("mid_pre_psel", bus.PSEL, 1);
        chk("mid_pre_pen",  bus.PENABLE, 1);
        #2 PRESETn = 1'b0;
        #1;
        chk("mid_rst_psel",   bus.PSEL, 0);
        chk("mid_rst_pen",    bus.PENABLE, 0);
        chk("mid_rst_paddr",  bus.PADDR, 0);
        chk("mid_rst_pwrite", bus.PWRITE, 0);
        chk("mid_rst_pstrb",  bus.PSTRB, 0);
        chk("mid_rst_pwdata", bus.PWDATA, 0);
        chk("mid_rst_busy",   bus.busy, 0);
        chk("mid_rst_ready",  bus.cmd_ready, 0);
        tick();
        PRESETn = 1'b1;
        bus.PREADY = 1;
        tick();
        chk("after_rst_busy",  bus.busy, 0);
        chk("after_rst_rspv",  bus.rsp_valid, 0);
        chk("after_rst_ready", bus.cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stale_rsp_valid", bus.rsp_valid, 0);
            chk("stale_psel",      bus.PSEL, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/peripheral_apb4_cmd_master.md
# peripheral_apb4_cmd_master

Synthesizable, parametrised AMBA4 APB master that turns a queued valid/ready command stream into APB4 transfers and returns per-transfer responses on a valid/ready response stream. It sits between a DMA/control engine and the APB peripheral fabric. It adds the following to a single-transfer bus driver:
- command buffering and back-to-back transfers;
- wait-state handling with a timeout abort;
- PSLVERR/timeout reporting.

## Interface
- PADDR_SIZE, 16, APB address width
- PDATA_SIZE, 32, APB data width (multiple of 8)
- CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- RSP_DEPTH, 2, response FIFO entries (power of 2, ≥1)
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort (0 = never)

Ports:
- PCLK  in  1  clock, all logic on rising edge
- PRESETn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO not full
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  PADDR_SIZE  target address
- cmd_strb  in  PDATA_SIZE/8  write strobes
- cmd_wdata  in  PDATA_SIZE  write data
- rsp_valid  out  1  response FIFO not empty
- rsp_ready  in  1  response consumed
- rsp_rdata  out  PDATA_SIZE  read data (0 for writes and timeouts)
- rsp_err  out  1  PSLVERR sampled, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- busy  out  1  command FIFO non-empty or FSM not IDLE
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  PADDR_SIZE  APB address
- PSTRB  out  PDATA_SIZE/8  APB strobes
- PWDATA  out  PDATA_SIZE  APB write data
- PRDATA  in  PDATA_SIZE  APB read data
- PREADY, PSLVERR  in  1  APB completion and error

## Operation
- **Command intake:** a command is pushed when `cmd_valid && cmd_ready`.
- **Response output:** a response is popped when `rsp_valid && rsp_ready`. Both FIFOs are first-word-fall-through with registered count.
- **Transfer order:** one APB transfer in flight at most. Transfers are issued in command order.
- **Launch rule:** SETUP may be entered only when the command FIFO is non-empty and the response FIFO has a free slot, using count after any same-cycle pop and push. A completing transfer therefore always has space for its response.
- **FSM states:** IDLE, SETUP, ACCESS.
  - IDLE → SETUP when the launch rule holds.
  - SETUP → ACCESS unconditionally.
  - ACCESS → SETUP on completion if the launch rule holds for the next head.
  - ACCESS → IDLE on completion otherwise.
  - ACCESS stays in ACCESS while PREADY is low and no timeout.
- **APB signal drive:**
  - IDLE: PSEL=0, PENABLE=0, PADDR/PSTRB/PWDATA/PWRITE = 0.
  - SETUP: PSEL=1, PENABLE=0, fields from the FIFO head.
  - ACCESS: PSEL=1, PENABLE=1, fields held stable.
  - Reads drive PSTRB=0 and PWDATA=0.
- **Completion:** completion is a rising edge in ACCESS with PREADY=1. At that edge:
  - the command FIFO pops;
  - the response pushes with `rsp_err=PSLVERR`, `rsp_timeout=0`;
  - `rsp_rdata` = PRDATA for reads, 0 for writes.
- **Timeout:** the wait counter clears on SETUP and increments on each ACCESS edge with PREADY=0. If TIMEOUT≠0 and the counter reaches TIMEOUT-1 while PREADY=0, the transfer aborts:
  - the command pops;
  - the response pushes with `rsp_err=1`, `rsp_timeout=1`, `rsp_rdata=0`;
  - the FSM follows the same next-state rule as a normal completion.
- **Reset values:** all outputs are 0 at reset (cmd_ready=0 during reset, 1 the first cycle after). FIFOs are empty, FSM is IDLE, counter is 0.
- **Reset mid-transfer:** outputs clear immediately (asynchronously). The in-flight command and all queued commands and responses are discarded; no response is produced.

## Timing
- **Minimum latency:** command accepted at edge T → SETUP in cycle T..T+1 (PSEL=1 after edge T) → ACCESS after edge T+1. With zero wait states, completion occurs at edge T+2 and rsp_valid=1 after edge T+2.
- **Throughput:** back-to-back zero-wait transfers take 2 cycles each, with no IDLE cycle between them.
- **Wait states:** each PREADY-low cycle adds 1 cycle. A timeout transfer occupies exactly TIMEOUT ACCESS cycles.
- **Full command FIFO:** cmd_ready=0. A same-cycle pop does not raise cmd_ready combinationally; it rises the next cycle.
- **Full response FIFO with rsp_ready low:** no new SETUP is issued. The FSM idles and busy stays 1.
- **Simultaneous push and pop:** the count is unchanged. With the FIFO empty, a push is not visible until the next cycle.
- **busy** is registered and falls the cycle after the last completion when the FIFO is empty.

## Test plan
- **Single write:** write addr 0x0010, strb 0xF, data 0xDEADBEEF; PREADY tied 1.
  - Required: PSEL high 2 cycles, PENABLE high in the 2nd.
  - Required: response err=0, rdata=0.
- **Single read:** read addr 0x0020 with 3 wait states, PRDATA=0x12345678 at completion.
  - Required: ACCESS lasts 4 cycles, PSTRB=0 throughout.
  - Required: response rdata=0x12345678, err=0.
- **Queue and back-pressure:** push 4 writes back-to-back with rsp_ready=0 and RSP_DEPTH=2.
  - Required: exactly 2 transfers run, then PSEL stays 0 and cmd_ready stays 1 with 2 entries queued.
  - Required: after raising rsp_ready, the remaining 2 transfers complete in order, 2 cycles each.
- **Error and timeout:**
  - Read with PSLVERR=1 at completion → err=1, timeout=0.
  - Write with PREADY held 0 and TIMEOUT=16 → PSEL drops after 16 ACCESS cycles; response err=1, timeout=1, rdata=0.
- **Reset mid-ACCESS:** assert PRESETn low during a wait state with 2 commands queued.
  - Required: all APB outputs are 0 immediately.
  - Required: after release, busy=0, rsp_valid=0, cmd_ready=1, and no stale response appears.
